// File: rtl/led_show_sequencer_pkg.sv
// Shared definitions for the LED show playlist: entry field layout, table depth, FSM states.
package led_seq_pkg;

    localparam int ENTRY_W     = 12;
    localparam int FIELD_W     = 4;
    localparam int MODE_MSB    = 11;
    localparam int SPEED_MSB   = 7;
    localparam int DUR_MSB     = 3;
    localparam int TABLE_DEPTH = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [FIELD_W-1:0] entry_mode(input logic [ENTRY_W-1:0] e);
        return e[MODE_MSB -: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] entry_speed(input logic [ENTRY_W-1:0] e);
        return e[SPEED_MSB -: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_MSB -: FIELD_W];
    endfunction

endpackage

// File: rtl/led_show_sequencer_beat_timer.sv
// Free-running beat counter: pulses beat on the last cycle of each BEAT_CYCLES period while enabled.
module beat_timer #(
    parameter int BEAT_CYCLES = 50_000_000
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic beat
);

    localparam int CNT_W = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clkin) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Gated by en so a count frozen at LAST during pause cannot fire.
    assign beat = en && (count == LAST);

endmodule

// File: rtl/led_show_sequencer.sv
// Playlist sequencer feeding knightrider mode/speed from an 8-entry {mode, speed, dur} table.
//   state | meaning
//   IDLE  | after reset, outputs 0, waiting for run
//   PLAY  | timer running, entries advance on expiry or step
//   PAUSE | timer and beats_left frozen, outputs held, step still advances
//   DONE  | one-shot finished, last entry held, step restarts at entry 0
module led_show_sequencer
    import led_seq_pkg::*;
#(
    parameter int BEAT_CYCLES = 50_000_000,
    parameter int LOOP        = 1
) (
    input  logic         clkin,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [11:0]  wr_data,
    input  logic [2:0]   last_idx,
    input  logic         run,
    input  logic         next_btn,
    output logic [3:0]   mode_out,
    output logic [3:0]   speed_out,
    output logic [2:0]   idx,
    output logic         playing,
    output logic         done
);

    logic [ENTRY_W-1:0] table_q [TABLE_DEPTH];
    state_t             state, state_next;
    logic               next_btn_q;
    logic               step;
    logic               beat;
    logic               expiry;
    logic               load;
    logic               dec;
    logic               done_next;
    logic [IDX_W-1:0]   load_addr;
    logic [IDX_W-1:0]   next_idx;
    logic [ENTRY_W-1:0] load_entry;
    logic [3:0]         beats_left;

    assign step       = next_btn & ~next_btn_q;
    assign expiry     = beat && (beats_left == 4'd0);
    // ">=" rather than "==" so a last_idx lowered mid-play still wraps.
    assign next_idx   = (idx >= last_idx) ? '0 : idx + 3'd1;
    assign load_entry = table_q[load_addr];
    assign playing    = (state == PLAY);

    beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
        .clkin (clkin),
        .rst   (rst),
        .en    (state == PLAY),
        .clr   (load),
        .beat  (beat)
    );

    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_addr  = next_idx;
        dec        = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    load       = 1'b1;
                    load_addr  = '0;
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (expiry || step) begin
                    if (expiry && (LOOP == 0) && (idx >= last_idx)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end else begin
                    dec = beat;
                    if (!run) state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (step) begin
                    load = 1'b1;
                end else if (run) begin
                    state_next = PLAY;
                end
            end
            DONE: begin
                if (step) begin
                    load       = 1'b1;
                    load_addr  = '0;
                    state_next = run ? PLAY : PAUSE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
            next_btn_q <= 1'b0;
            mode_out   <= '0;
            speed_out  <= '0;
            idx        <= '0;
            beats_left <= '0;
            done       <= 1'b0;
        end else begin
            next_btn_q <= next_btn;
            done       <= done_next;
            // Load reads the pre-write table, so a same-edge write shows on the next load.
            if (wr_en) table_q[wr_addr] <= wr_data;
            if (load) begin
                mode_out   <= entry_mode(load_entry);
                speed_out  <= entry_speed(load_entry);
                idx        <= load_addr;
                beats_left <= entry_dur(load_entry);
            end else if (dec) begin
                beats_left <= beats_left - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_show_sequencer.sv
// Directed bench for led_show_sequencer with a looping and a one-shot instance on shared inputs.
module tb_led_show_sequencer;

    localparam int BEAT = 4;

    logic        clkin = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic [2:0]  last_idx;
    logic        run;
    logic        next_btn;

    logic [3:0]  mode_l, speed_l, mode_o, speed_o;
    logic [2:0]  idx_l, idx_o;
    logic        playing_l, done_l, playing_o, done_o;

    logic [12:0] vec_loop, vec_once;
    assign vec_loop = {mode_l, speed_l, idx_l, playing_l, done_l};
    assign vec_once = {mode_o, speed_o, idx_o, playing_o, done_o};

    string       tag_q[$];
    logic [12:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          sel_once = 1'b0;

    always #5 clkin = ~clkin;

    led_show_sequencer #(.BEAT_CYCLES(BEAT), .LOOP(1)) dut_loop (
        .clkin(clkin), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_idx(last_idx), .run(run), .next_btn(next_btn),
        .mode_out(mode_l), .speed_out(speed_l), .idx(idx_l), .playing(playing_l), .done(done_l)
    );

    led_show_sequencer #(.BEAT_CYCLES(BEAT), .LOOP(0)) dut_once (
        .clkin(clkin), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_idx(last_idx), .run(run), .next_btn(next_btn),
        .mode_out(mode_o), .speed_out(speed_o), .idx(idx_o), .playing(playing_o), .done(done_o)
    );

    // Push the expectation for the coming edge, then pop and compare once it has settled.
    task automatic cyc(input string tag, input logic [3:0] m, input logic [3:0] s,
                       input logic [2:0] i, input logic p, input logic d);
        string       t;
        logic [12:0] e;
        logic [12:0] o;
        tag_q.push_back(tag);
        exp_q.push_back({m, s, i, p, d});
        @(negedge clkin);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        o = sel_once ? vec_once : vec_loop;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed {mode,speed,idx,playing,done}=%h expected %h", t, o, e);
        end
    endtask

    task automatic cycn(input int n, input string tag, input logic [3:0] m, input logic [3:0] s,
                        input logic [2:0] i, input logic p, input logic d);
        for (int k = 0; k < n; k++) cyc(tag, m, s, i, p, d);
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] dv);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = dv;
        cyc("idle_write", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        last_idx = 3'd7;
        run      = 1'b0;
        next_btn = 1'b0;

        // reset, then empty table walks all eight entries
        cycn(2, "reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        run = 1'b1;
        for (int e = 0; e < 9; e++) cycn(BEAT, "empty_walk", 4'd0, 4'd0, 3'(e), 1'b1, 1'b0);
        rst = 1'b1;
        run = 1'b0;
        cyc("reset_again", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // loop play
        last_idx = 3'd2;
        wr(3'd0, 12'h210);
        wr(3'd1, 12'h631);
        wr(3'd2, 12'hC00);
        run = 1'b1;
        cycn(4, "loop_e0", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);
        cycn(8, "loop_e1", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        cycn(4, "loop_e2", 4'd12, 4'd0, 3'd2, 1'b1, 1'b0);
        cycn(4, "loop_wrap", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);

        // pause after 3 cycles of entry 1, resume with 5 cycles left
        cycn(3, "pre_pause", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        run = 1'b0;
        cycn(20, "paused", 4'd6, 4'd3, 3'd1, 1'b0, 1'b0);
        run = 1'b1;
        cycn(5, "resumed", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        cycn(4, "after_resume", 4'd12, 4'd0, 3'd2, 1'b1, 1'b0);

        // held button gives one step
        cyc("before_step", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);
        next_btn = 1'b1;
        cycn(8, "held_step_e1", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        cycn(2, "held_step_e2", 4'd12, 4'd0, 3'd2, 1'b1, 1'b0);
        next_btn = 1'b0;
        cycn(2, "release_e2", 4'd12, 4'd0, 3'd2, 1'b1, 1'b0);
        cycn(4, "pre_coincide", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);

        // step on the expiry cycle advances once
        next_btn = 1'b1;
        cyc("coincide", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        next_btn = 1'b0;
        cycn(7, "coincide_e1", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        cyc("coincide_e2", 4'd12, 4'd0, 3'd2, 1'b1, 1'b0);

        // one-shot instance
        sel_once = 1'b1;
        rst = 1'b1;
        run = 1'b0;
        cyc("once_reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        wr(3'd0, 12'h210);
        wr(3'd1, 12'h631);
        wr(3'd2, 12'hC00);
        run = 1'b1;
        cycn(4, "once_e0", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);
        cycn(8, "once_e1", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);
        cycn(4, "once_e2", 4'd12, 4'd0, 3'd2, 1'b1, 1'b0);
        cyc("once_done_pulse", 4'd12, 4'd0, 3'd2, 1'b0, 1'b1);
        cycn(3, "once_done_hold", 4'd12, 4'd0, 3'd2, 1'b0, 1'b0);
        next_btn = 1'b1;
        cyc("once_restart", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);
        next_btn = 1'b0;
        cycn(3, "once_restart_e0", 4'd2, 4'd1, 3'd0, 1'b1, 1'b0);
        cycn(2, "once_restart_e1", 4'd6, 4'd3, 3'd1, 1'b1, 1'b0);

        // reset mid-play clears table and state
        rst = 1'b1;
        cyc("midplay_reset", 4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cycn(2, "cleared_table", 4'd0, 4'd0, 3'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
